// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding, widths and modular address helper for the FIR tap sequencer
package fir_pkg;
    typedef enum logic [2:0] {IDLE, WRITE, CLEAR, RUN, DRAIN, DONE} state_t;
    localparam int AUD_W = 24;
    localparam int COEF_W = 16;
    localparam int ACC_OUT_W = 32;
    function automatic logic [31:0] mod_dec(input logic [31:0] a, input logic [31:0] n);
        return (a == 32'd0) ? n - 32'd1 : a - 32'd1;
    endfunction
endpackage

// File: rtl/fir_delay_ptr.sv
// fir_delay_ptr: circular delay-line write pointer and newest-to-oldest read address walker
// Ports: clk, reset_n (async, active low); i_write advances the write pointer and loads the
// read walker with the address being written; i_run steps the walker back one slot;
// o_wr_ptr is the current write address, o_rd_addr the current read address.
module fir_delay_ptr
    import fir_pkg::*;
#(
    parameter int NUM_TAPS = 64,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_write,
    input  logic              i_run,
    output logic [ADDR_W-1:0] o_wr_ptr,
    output logic [ADDR_W-1:0] o_rd_addr
);
    logic [ADDR_W-1:0] r_wr;
    logic [ADDR_W-1:0] r_rd;
    // Wrap is explicit at NUM_TAPS-1 so non-power-of-two tap counts work.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            r_wr <= !i_write ? r_wr : (r_wr == ADDR_W'(NUM_TAPS - 1)) ? '0 : r_wr + 1'b1;
            r_rd <= i_write ? r_wr : i_run ? ADDR_W'(mod_dec(32'(r_rd), 32'(NUM_TAPS))) : r_rd;
        end
    end
    assign o_wr_ptr = r_wr;
    assign o_rd_addr = r_rd;
endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: time-multiplexed sequencer driving one FIR multiply-accumulate tap
// Ports: clk, reset_n (async, active low); audio_en/aud_sample_in new-sample strobe;
// smp_wr_* delay-line write; smp_rd_addr and coef_addr read addresses (latency 1);
// coef_gate, data_en, accum_clr tap controls; acc_in tap result; audio_out/audio_out_valid
// captured output; busy (not IDLE); overrun (sticky strobe-while-busy).
// Optional: FIR_COEF_BANK_EN adds coef_bank and widens coef_addr by one bank-select MSB.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int NUM_TAPS = 64,
    parameter int ADDR_W = 8,
    parameter int MULT_LAT = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 audio_en,
    input  logic [AUD_W-1:0]     aud_sample_in,
`ifdef FIR_COEF_BANK_EN
    input  logic                 coef_bank,
    output logic [ADDR_W:0]      coef_addr,
`else
    output logic [ADDR_W-1:0]    coef_addr,
`endif
    output logic                 smp_wr_en,
    output logic [ADDR_W-1:0]    smp_wr_addr,
    output logic [AUD_W-1:0]     smp_wr_data,
    output logic [ADDR_W-1:0]    smp_rd_addr,
    output logic                 coef_gate,
    output logic                 data_en,
    output logic                 accum_clr,
    input  logic [ACC_OUT_W-1:0] acc_in,
    output logic [ACC_OUT_W-1:0] audio_out,
    output logic                 audio_out_valid,
    output logic                 busy,
    output logic                 overrun
);
    localparam int DRAIN_N = MULT_LAT + 2;
    localparam int CNT_W = ((ADDR_W > $clog2(DRAIN_N)) ? ADDR_W : $clog2(DRAIN_N)) + 1;
    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_k;
    logic [AUD_W-1:0]   r_sample;
    logic               r_arm;
    logic               r_gate;
    logic               r_valid;
    logic               r_ovr;
    logic [ACC_OUT_W-1:0] r_out;
    logic [ADDR_W-1:0]  w_wr_ptr;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic               w_run_last;
    logic               w_drain_last;
    logic               w_start;
    logic [ADDR_W-1:0]  w_coef_lo;
    assign w_run_last = r_k == CNT_W'(NUM_TAPS - 1);
    assign w_drain_last = r_k == CNT_W'(DRAIN_N - 1);
    assign w_start = (r_state == IDLE) && (w_next == WRITE);
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (audio_en && r_arm) ? WRITE : IDLE;
            WRITE:   w_next = CLEAR;
            CLEAR:   w_next = RUN;
            RUN:     w_next = w_run_last ? DRAIN : RUN;
            DRAIN:   w_next = w_drain_last ? DONE : DRAIN;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    // r_arm blocks a strobe landing on the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_sample <= '0;
            r_arm    <= 1'b0;
            r_gate   <= 1'b0;
            r_valid  <= 1'b0;
            r_ovr    <= 1'b0;
            r_out    <= '0;
        end else begin
            r_state  <= w_next;
            r_k      <= (w_next != r_state || r_state == IDLE) ? '0 : r_k + 1'b1;
            r_sample <= w_start ? aud_sample_in : r_sample;
            r_arm    <= 1'b1;
            r_gate   <= r_state == RUN;
            r_valid  <= r_state == DONE;
            r_ovr    <= r_ovr | (audio_en && r_state != IDLE);
            r_out    <= (r_state == DONE) ? acc_in : r_out;
        end
    end
    fir_delay_ptr #(.NUM_TAPS(NUM_TAPS), .ADDR_W(ADDR_W)) u_ptr (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_write   (r_state == WRITE),
        .i_run     (r_state == RUN),
        .o_wr_ptr  (w_wr_ptr),
        .o_rd_addr (w_rd_addr)
    );
    assign w_coef_lo = (r_state == RUN) ? r_k[ADDR_W-1:0] : '0;
`ifdef FIR_COEF_BANK_EN
    // Bank is frozen at sequence start so a filter swap never splits one output sample.
    logic r_bank;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_bank <= 1'b0;
        else if (w_start) r_bank <= coef_bank;
    end
    assign coef_addr = {r_bank, w_coef_lo};
`else
    assign coef_addr = w_coef_lo;
`endif
    assign smp_wr_en = r_state == WRITE;
    assign smp_wr_addr = smp_wr_en ? w_wr_ptr : '0;
    assign smp_wr_data = smp_wr_en ? r_sample : '0;
    assign smp_rd_addr = (r_state == RUN) ? w_rd_addr : '0;
    assign coef_gate = r_gate;
    assign data_en = (r_state == RUN) || (r_state == DRAIN);
    assign accum_clr = r_state == CLEAR;
    assign audio_out = r_out;
    assign audio_out_valid = r_valid;
    assign busy = r_state != IDLE;
    assign overrun = r_ovr;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: directed and randomized checks of the FIR tap sequencer against a behavioural filter model
module tb_fir_tap_sequencer;
    localparam int N = 8;
    localparam int AW = 8;
    localparam int L = 3;
    localparam int LAT = N + L + 6;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic audio_en = 1'b0;
    logic [23:0] aud_sample_in = '0;
`ifdef FIR_COEF_BANK_EN
    logic coef_bank = 1'b0;
    logic [AW:0] coef_addr;
`else
    logic [AW-1:0] coef_addr;
`endif
    logic smp_wr_en, coef_gate, data_en, accum_clr, audio_out_valid, busy, overrun;
    logic [AW-1:0] smp_wr_addr, smp_rd_addr;
    logic [23:0] smp_wr_data;
    logic [31:0] acc_in, audio_out;
    int n_vec = 0;
    int n_miss = 0;
    int n_wr = 0;
    longint hist[$];
    logic signed [15:0] coef [0:255];
    logic signed [23:0] ram [0:255];
    logic signed [23:0] rd_s;
    logic signed [15:0] rd_c;
    logic signed [39:0] p [0:L-1];
    logic signed [47:0] acc;

    fir_tap_sequencer #(.NUM_TAPS(N), .ADDR_W(AW), .MULT_LAT(L)) dut (
        .clk(clk), .reset_n(reset_n), .audio_en(audio_en), .aud_sample_in(aud_sample_in),
`ifdef FIR_COEF_BANK_EN
        .coef_bank(coef_bank),
`endif
        .coef_addr(coef_addr), .smp_wr_en(smp_wr_en), .smp_wr_addr(smp_wr_addr),
        .smp_wr_data(smp_wr_data), .smp_rd_addr(smp_rd_addr), .coef_gate(coef_gate),
        .data_en(data_en), .accum_clr(accum_clr), .acc_in(acc_in), .audio_out(audio_out),
        .audio_out_valid(audio_out_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Tap model: latency-1 RAM/ROM, CE-gated multiplier pipeline, 48-bit accumulator.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
            for (int i = 0; i < L; i++) p[i] <= '0;
            rd_s <= '0;
            rd_c <= '0;
            acc <= '0;
        end else begin
            if (smp_wr_en) ram[smp_wr_addr] <= smp_wr_data;
            rd_s <= ram[smp_rd_addr];
            rd_c <= coef[coef_addr[AW-1:0]];
            if (data_en) begin
                p[0] <= coef_gate ? rd_c * rd_s : 40'sd0;
                for (int i = 1; i < L; i++) p[i] <= p[i-1];
            end
            acc <= accum_clr ? 48'sd0 : data_en ? acc + 48'(p[L-1]) : acc;
        end
    end
    assign acc_in = 32'(acc >>> 8);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, 64'({smp_wr_en, smp_wr_addr, smp_wr_data, smp_rd_addr, coef_addr,
             coef_gate, data_en, accum_clr, audio_out_valid, busy, overrun}), 64'd0);
        chk({tag, "_out"}, 64'(audio_out), 64'd0);
    endtask

    // One sample: expected output is the direct convolution of the newest N inputs.
    task automatic run_sample(input logic [23:0] x, input int extra_at);
        int newest;
        longint s;
        logic [31:0] y;
        logic eb;
        newest = n_wr % N;
        n_wr++;
        hist.push_front(longint'($signed(x)));
        if (hist.size() > N) void'(hist.pop_back());
        s = 0;
        for (int k = 0; k < hist.size(); k++) s += longint'(coef[k]) * hist[k];
        y = 32'(s >>> 8);
        eb = 1'b0;
`ifdef FIR_COEF_BANK_EN
        eb = coef_bank;
`endif
        audio_en = 1'b1;
        aud_sample_in = x;
        for (int c = 1; c <= 24; c++) begin
            tick();
            audio_en = 1'b0;
            chk("wr_en", 64'(smp_wr_en), 64'(c == 1));
            if (c == 1) begin
                chk("wr_addr", 64'(smp_wr_addr), 64'(newest));
                chk("wr_data", 64'(smp_wr_data), 64'(x));
            end
            chk("accum_clr", 64'(accum_clr), 64'(c == 2));
            chk("data_en", 64'(data_en), 64'(c >= 3 && c <= N + L + 4));
            chk("coef_gate", 64'(coef_gate), 64'(c >= 4 && c <= N + 3));
            chk("busy", 64'(busy), 64'(c <= N + L + 5));
            chk("valid", 64'(audio_out_valid), 64'(c == LAT));
            if (c == LAT) chk("audio_out", 64'(audio_out), 64'(y));
            if (c >= 3 && c <= N + 2) begin
                chk("coef_addr", 64'(coef_addr[AW-1:0]), 64'(c - 3));
                chk("rd_addr", 64'(smp_rd_addr), 64'(((newest - (c - 3)) % N + N) % N));
`ifdef FIR_COEF_BANK_EN
                chk("coef_bank", 64'(coef_addr[AW]), 64'(eb));
                if (c == 6) coef_bank = ~coef_bank;
`endif
            end
            if (c == extra_at) begin
                audio_en = 1'b1;
                aud_sample_in = 24'($urandom);
            end
        end
        repeat (6) tick();
    endtask

    initial begin
        for (int k = 0; k < 256; k++) coef[k] = 16'(k + 1);
        repeat (2) tick();
        chk_quiet("reset");
        // Strobe coincident with reset release must be ignored.
        reset_n = 1'b1;
        audio_en = 1'b1;
        aud_sample_in = 24'h00abcd;
        tick();
        audio_en = 1'b0;
        chk("release_busy", 64'(busy), 64'd0);
        tick();
        chk("release_wr", 64'(smp_wr_en | busy), 64'd0);
        // Impulse then zeros; ten strobes also exercise pointer wrap.
        run_sample(24'h000100, -1);
        for (int i = 0; i < 9; i++) run_sample(24'h0, -1);
        chk("no_overrun", 64'(overrun), 64'd0);
        // Randomized coefficients and samples.
        for (int k = 0; k < N; k++) coef[k] = 16'($urandom);
        for (int i = 0; i < 6; i++) run_sample(24'($urandom), -1);
        // Strobe while busy, then one coinciding with DONE.
        run_sample(24'($urandom), 5);
        chk("overrun_set", 64'(overrun), 64'd1);
        run_sample(24'($urandom), N + L + 5);
        run_sample(24'($urandom), -1);
        chk("overrun_sticky", 64'(overrun), 64'd1);
        // Asynchronous reset in the middle of RUN.
        audio_en = 1'b1;
        aud_sample_in = 24'h000007;
        tick();
        audio_en = 1'b0;
        repeat (5) tick();
        chk("pre_reset_run", 64'(data_en), 64'd1);
        reset_n = 1'b0;
        #1;
        chk_quiet("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        hist.delete();
        n_wr = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            chk("post_reset_valid", 64'(audio_out_valid | busy), 64'd0);
        end
        run_sample(24'h000100, -1);
        run_sample(24'($urandom), -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
Time-multiplexed controller for the single FIR tap datapath (24x16 multiply plus 48-bit accumulate). On each audio sample strobe it writes the new sample into a circular delay-line RAM. It then walks NUM_TAPS coefficient/sample address pairs, drives the tap's clock-enable, accumulator clear and coefficient gate, and captures the filtered result with a valid pulse. It sits between the I2S/sample-rate strobe logic and the FIR tap; one instance per channel.

Parameters:
NUM_TAPS, 64, taps per output sample (2..256)
ADDR_W, 8, width of coefficient and delay-line addresses; NUM_TAPS <= 2**ADDR_W
MULT_LAT, 3, pipeline latency of the tap multiplier in CE-enabled cycles

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
audio_en  in  1  one-cycle sample strobe; new input sample available
aud_sample_in  in  24  signed input sample, valid with audio_en
smp_wr_en  out  1  delay-line RAM write enable
smp_wr_addr  out  ADDR_W  delay-line write address
smp_wr_data  out  24  delay-line write data
smp_rd_addr  out  ADDR_W  delay-line read address (RAM read latency 1)
coef_addr  out  ADDR_W  coefficient ROM/RAM address (read latency 1)
coef_gate  out  1  1 = pass coefficient to multiplier, 0 = force zero
data_en  out  1  CE to multiplier and accumulator
accum_clr  out  1  synchronous clear to accumulator
acc_in  in  32  accumulator result, already scaled by the tap
audio_out  out  32  captured filter output
audio_out_valid  out  1  one-cycle pulse when audio_out updates
busy  out  1  high in every state except IDLE
overrun  out  1  sticky; strobe arrived while busy

Behaviour:
- Reset: all outputs 0; wr_ptr = 0; state IDLE. Reset mid-sequence aborts with no output pulse.
- States: IDLE -> WRITE -> CLEAR -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE: audio_en=1 latches aud_sample_in and moves to WRITE.
- WRITE (1 cycle): smp_wr_en=1, smp_wr_addr=wr_ptr, smp_wr_data=latched sample. Then wr_ptr <= (wr_ptr+1) mod NUM_TAPS, with an explicit wrap at NUM_TAPS-1 that does not depend on 2**ADDR_W.
- CLEAR (1 cycle): accum_clr=1, data_en=0.
- RUN (NUM_TAPS cycles, k=0..NUM_TAPS-1):
  - coef_addr=k.
  - smp_rd_addr=(newest - k) mod NUM_TAPS, where newest = address written in WRITE; wrap from 0 goes to NUM_TAPS-1.
  - coef_gate is the RUN-cycle indicator delayed 1 cycle to align with RAM read data.
  - data_en=1.
- DRAIN (MULT_LAT+2 cycles): data_en=1, coef_gate=0 after its 1-cycle delay expires. This flushes real products into the accumulator and leaves zeros in the multiplier pipeline for the next sample.
- DONE (1 cycle): audio_out <= acc_in, audio_out_valid=1, data_en=0.
- Latency: with the audio_en cycle as 0, audio_out_valid is high in cycle NUM_TAPS+MULT_LAT+6.
- audio_en while busy:
  - overrun <= 1, sticky until reset; the strobe is ignored.
  - If it coincides with DONE, it is also ignored; IDLE must see it.
- audio_en in the same cycle as the reset release is ignored.
- data_en is never high in IDLE, WRITE, CLEAR or DONE.
- accum_clr is high only in CLEAR.

Optional Feature:
Macro: FIR_COEF_BANK_EN.
- Defined:
  - Adds input coef_bank (1 bit); coef_addr widens to ADDR_W+1.
  - The MSB of coef_addr is coef_bank sampled in the IDLE->WRITE transition and held constant for the whole sequence. A mid-sequence change takes effect on the next sample only, giving glitch-free filter swaps.
- Undefined: no coef_bank port; coef_addr is ADDR_W bits.

Decomposition:
- Shared package fir_pkg:
  - state enum (IDLE, WRITE, CLEAR, RUN, DRAIN, DONE)
  - AUD_W=24, COEF_W=16, ACC_OUT_W=32
  - function for modular address decrement
- One natural sub-module, fir_delay_ptr: wr_ptr register plus the modular read-address generator.

Test Plan:
- NUM_TAPS=8, MULT_LAT=3; reset, then single audio_en with sample 0x000100 -> smp_wr_en at cycle 1, addr 0. accum_clr at cycle 2. coef_addr 0..7 on cycles 3..10. data_en high cycles 3..15. audio_out_valid at cycle 17.
- Address wrap: 10 strobes spaced 30 cycles apart -> 10th write at addr 1. RUN reads 1,0,7,6,5,4,3,2.
- Impulse response: coefficients k+1, impulse 0x000100 then zeros. Use a behavioural tap model -> outputs follow the scaled coefficient sequence 1..8, then 0.
- Overrun: second audio_en 5 cycles after the first -> overrun=1, exactly one audio_out_valid, wr_ptr advanced once.
- Reset asserted in RUN (cycle 6) -> all outputs 0 asynchronously. No audio_out_valid. The next strobe after release writes addr 0.
- With FIR_COEF_BANK_EN: toggle coef_bank during RUN -> coef_addr MSB is unchanged until the next sample's WRITE.
